led_frame_serializer: RTL and testbench

Upstream feeder for the WS2812 `bit_transmitter`. It reads a frame of 24-bit GRB pixel words from the snake frame buffer (synchronous RAM, 1-cycle read latency) and presents them one bit at a time, MSB first. It advances one bit per `new_bit_rqst` pulse. After the last bit of the last LED it raises `all_bits_shifted`. It restarts the frame on `new_frame_rqst`.

---
 rtl/led_frame_serializer.sv | 114 +++++++++++
 tb/tb_led_frame_serializer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/led_frame_serializer.sv
// Frame-buffer to WS2812 bit serializer: fetches GRB pixel words from a
// 1-cycle-latency RAM, prefetches the next pixel, and hands out bits MSB first.
module led_frame_serializer #(
  parameter int NUM_LEDS = 64,
  parameter int ADDR_W   = 6,
  parameter int PIX_W    = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              new_frame_rqst,
  input  logic              new_bit_rqst,
  output logic              bit_to_transmit,
  output logic              all_bits_shifted,
  output logic              frame_done,
  output logic              bit_valid,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [PIX_W-1:0]  pix_data
);

  localparam int CNT_W = $clog2(PIX_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(PIX_W - 1);
  localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

  state_t            state;
  logic [PIX_W-1:0]  shreg, next_pix;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] led_cnt;
  logic              pf_pend;  // prefetch address sampled by the RAM on the next edge
  logic              pf_land;  // prefetch data is on pix_data this cycle

  logic [ADDR_W:0] pf_next;
  assign pf_next = {1'b0, led_cnt} + (ADDR_W+1)'(2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      shreg            <= '0;
      next_pix         <= '0;
      bit_cnt          <= '0;
      led_cnt          <= '0;
      pf_pend          <= 1'b0;
      pf_land          <= 1'b0;
      bit_to_transmit  <= 1'b0;
      all_bits_shifted <= 1'b0;
      frame_done       <= 1'b0;
      bit_valid        <= 1'b0;
      pix_rd           <= 1'b0;
      pix_addr         <= '0;
    end else begin
      pix_rd     <= 1'b0;
      frame_done <= 1'b0;
      pf_land    <= pf_pend;
      pf_pend    <= 1'b0;
      if (pf_land) next_pix <= pix_data;

      if (new_frame_rqst) begin
        // abort whatever is in progress; a coincident bit request is dropped
        state            <= FETCH;
        pix_rd           <= 1'b1;
        pix_addr         <= '0;
        pf_pend          <= 1'b0;
        pf_land          <= 1'b0;
        all_bits_shifted <= 1'b0;
        bit_valid        <= 1'b0;
        bit_to_transmit  <= 1'b0;
      end else begin
        case (state)
          FETCH: state <= LOAD;
          LOAD: begin
            shreg           <= pix_data;
            bit_to_transmit <= pix_data[PIX_W-1];
            bit_cnt         <= '0;
            led_cnt         <= '0;
            bit_valid       <= 1'b1;
            state           <= SHIFT;
            if (NUM_LEDS > 1) begin
              pix_rd   <= 1'b1;
              pix_addr <= ADDR_W'(1);
              pf_pend  <= 1'b1;
            end
          end
          SHIFT: if (new_bit_rqst) begin
            if (bit_cnt < LAST_BIT) begin
              shreg           <= shreg << 1;
              bit_to_transmit <= shreg[PIX_W-2];
              bit_cnt         <= bit_cnt + 1'b1;
            end else if (led_cnt < LAST_LED) begin
              shreg           <= next_pix;
              bit_to_transmit <= next_pix[PIX_W-1];
              bit_cnt         <= '0;
              led_cnt         <= led_cnt + 1'b1;
              if (pf_next <= {1'b0, LAST_LED}) begin
                pix_rd   <= 1'b1;
                pix_addr <= pf_next[ADDR_W-1:0];
                pf_pend  <= 1'b1;
              end
            end else begin
              state            <= DONE;
              bit_valid        <= 1'b0;
              bit_to_transmit  <= 1'b0;
              all_bits_shifted <= 1'b1;
              frame_done       <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Directed + randomized bench for led_frame_serializer; the expected bit stream
// is the frame buffer contents concatenated pixel by pixel, MSB first.
module tb_led_frame_serializer;
  localparam int N  = 3;
  localparam int AW = 2;
  localparam int PW = 24;
  localparam int FB = N * PW;

  logic clk = 1'b0, rstn = 1'b0, nfr = 1'b0, nbr = 1'b0;
  logic btt, abs_o, fd, bv, prd;
  logic [AW-1:0] paddr;
  logic [PW-1:0] pdata = '0;
  logic [PW-1:0] mem [N];
  int rd_cnt [4];
  int fd_cnt = 0;
  int passed = 0, total = 0, fails = 0;

  led_frame_serializer #(.NUM_LEDS(N), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk(clk), .rstn(rstn), .new_frame_rqst(nfr), .new_bit_rqst(nbr),
    .bit_to_transmit(btt), .all_bits_shifted(abs_o), .frame_done(fd),
    .bit_valid(bv), .pix_rd(prd), .pix_addr(paddr), .pix_data(pdata)
  );

  always #5 clk = ~clk;

  // synchronous RAM model, one cycle read latency
  always @(posedge clk) if (prd) pdata <= (int'(paddr) < N) ? mem[paddr] : '0;

  always @(negedge clk) begin
    if (prd) rd_cnt[paddr] = rd_cnt[paddr] + 1;
    if (fd) fd_cnt = fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [FB-1:0] obs, input logic [FB-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [FB-1:0] model_stream();
    logic [FB-1:0] s = '0;
    for (int i = 0; i < N; i++) s = (s << PW) | FB'(mem[i]);
    return s;
  endfunction

  function automatic int rd_total();
    return rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
  endfunction

  task automatic run_frame(input string tag, input int nbits, input bit with_bit, input bit rand_gap);
    logic [FB-1:0] obs, exp, mask;
    int base [4];
    int fd0, gap, bv_low;
    exp = model_stream();
    obs = '0;
    base = rd_cnt;
    fd0 = fd_cnt;
    bv_low = 0;
    nfr = 1'b1; nbr = with_bit; tick(); nfr = 1'b0; nbr = 1'b0;
    check({tag, "/fetch"}, FB'({prd, paddr, bv, abs_o}), FB'({1'b1, 2'd0, 1'b0, 1'b0}));
    tick();
    check({tag, "/load"}, FB'({prd, bv}), FB'(0));
    tick();
    check({tag, "/first"}, FB'({bv, prd, paddr, btt}), FB'({1'b1, 1'b1, 2'd1, exp[FB-1]}));
    for (int k = 0; k < nbits; k++) begin
      gap = rand_gap ? int'($urandom_range(40, 3)) : 40;
      repeat (gap - 1) tick();
      if (!bv) bv_low++;
      obs[FB-1-k] = btt;
      nbr = 1'b1; tick(); nbr = 1'b0;
    end
    if (nbits == FB) begin
      check({tag, "/stream"}, obs, exp);
      check({tag, "/valid"}, FB'(bv_low), FB'(0));
      check({tag, "/end"}, FB'({abs_o, fd, bv}), FB'({1'b1, 1'b1, 1'b0}));
      tick();
      check({tag, "/end+1"}, FB'({abs_o, fd}), FB'({1'b1, 1'b0}));
      check({tag, "/reads"}, FB'({8'(rd_cnt[0]-base[0]), 8'(rd_cnt[1]-base[1]),
                                  8'(rd_cnt[2]-base[2]), 8'(rd_cnt[3]-base[3])}),
            FB'(32'h01010100));
      check({tag, "/fd_count"}, FB'(fd_cnt - fd0), FB'(1));
    end else begin
      mask = ~({FB{1'b1}} >> nbits);
      check({tag, "/partial"}, obs & mask, exp & mask);
    end
  endtask

  initial begin
    int fd0, rd0;
    for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    mem[0] = 24'hFF0000; mem[1] = 24'h00A5A5; mem[2] = 24'h800001;

    repeat (3) tick();
    check("reset", FB'({btt, abs_o, fd, bv, prd, paddr}), FB'(0));
    rstn = 1'b1;
    repeat (100) tick();
    check("idle_out", FB'({btt, abs_o, fd, bv, prd, paddr}), FB'(0));
    check("idle_rd", FB'(rd_total()), FB'(0));

    run_frame("f1", FB, 1'b0, 1'b0);

    // bit requests while DONE must not disturb anything
    fd0 = fd_cnt; rd0 = rd_total();
    repeat (10) begin
      nbr = 1'b1; tick(); nbr = 1'b0;
      repeat (2) tick();
    end
    check("done_hold", FB'({abs_o, bv, btt}), FB'({1'b1, 1'b0, 1'b0}));
    check("done_quiet", FB'({16'(fd_cnt - fd0), 16'(rd_total() - rd0)}), FB'(0));

    run_frame("f2", FB, 1'b0, 1'b0);

    run_frame("part", 30, 1'b0, 1'b0);
    run_frame("abort", FB, 1'b1, 1'b0);

    // async reset in the middle of pixel 1
    run_frame("pre_rst", 30, 1'b0, 1'b0);
    check("pre_rst_valid", FB'(bv), FB'(1));
    @(posedge clk); #3;
    rstn = 1'b0; #1;
    check("async_rst", FB'({btt, abs_o, fd, bv, prd, paddr}), FB'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    rd0 = rd_total();
    repeat (20) begin
      nbr = 1'b1; tick(); nbr = 1'b0;
      tick(); tick();
    end
    check("post_rst_idle", FB'({btt, abs_o, bv, prd}), FB'(0));
    check("post_rst_rd", FB'(rd_total() - rd0), FB'(0));
    run_frame("post_rst", FB, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) mem[i] = PW'($urandom);
      run_frame($sformatf("rnd%0d", r), FB, 1'b0, 1'b1);
    end

    check("addr3_never", FB'(rd_cnt[3]), FB'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
